// File: rtl/md_issue_ctrl.sv
// Issue-side shadow of the HI/LO multiply/divide unit: decodes D/E instructions,
// models the unit's busy window, stalls D on HI/LO hazards and checks the unit's handshake.
//   state | meaning
//   IDLE  | no operation in flight, unit free
//   MUL   | mult/multu in flight, remain counts down from MUL_LAT
//   DIV   | div/divu in flight, remain counts down from DIV_LAT
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_D,
    input  logic [31:0]      instr_E,
    input  logic             req,
    input  logic             start,
    input  logic             busy,
    output logic             stall,
    output logic             pending,
    output logic [CNT_W-1:0] remain,
    output logic             proto_err,
    output logic [31:0]      stall_cnt
);

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remain_nxt;
    logic             md_D, start_E, is_div_E;
    logic             unused_bits;

    function automatic logic is_special(input logic [31:0] instr);
        return instr[31:26] == 6'b000000;
    endfunction

    // mult/multu/div/divu share funct prefix 0110, mf/mt HI/LO share 0100
    always_comb begin
        md_D     = is_special(instr_D) &&
                   (instr_D[5:2] == 4'b0110 || instr_D[5:2] == 4'b0100);
        start_E  = is_special(instr_E) && (instr_E[5:2] == 4'b0110);
        is_div_E = start_E && instr_E[1];
    end

    assign unused_bits = ^{instr_D[25:6], instr_E[25:6]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remain    <= '0;
            proto_err <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            remain    <= remain_nxt;
            proto_err <= proto_err | (pending != busy) | (start != start_E);
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // A flush freezes the unit, so the shadow freezes with it
    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        if (!req) begin
            case (state)
                IDLE: begin
                    if (start_E) begin
                        state_nxt  = is_div_E ? DIV : MUL;
                        remain_nxt = is_div_E ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    end
                end
                MUL, DIV: begin
                    remain_nxt = remain - 1'b1;
                    if (remain <= CNT_W'(1)) begin
                        state_nxt  = IDLE;
                        remain_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    remain_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        pending = (state != IDLE);
        stall   = md_D & (start_E | pending);
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: stimulus pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares; a small unit model drives start/busy.
module tb_md_issue_ctrl;

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] MULT = 32'h0085_0018;
    localparam logic [31:0] DIV  = 32'h0085_001A;
    localparam logic [31:0] DIVU = 32'h0085_001B;
    localparam logic [31:0] MFHI = 32'h0000_1010;
    localparam logic [31:0] MFLO = 32'h0000_1012;
    localparam logic [31:0] ADDU = 32'h0085_1021;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_D = NOP;
    logic [31:0] instr_E = NOP;
    logic        req = 1'b0;
    logic        start, busy;
    logic        stall, pending, proto_err;
    logic [3:0]  remain;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    md_issue_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .instr_E(instr_E),
        .req(req), .start(start), .busy(busy), .stall(stall),
        .pending(pending), .remain(remain), .proto_err(proto_err),
        .stall_cnt(stall_cnt)
    );

    // Behavioural HI/LO unit; drop_early makes a div release busy one cycle early
    int  ucnt = 0;
    bit  udiv = 1'b0;
    bit  drop_early = 1'b0;
    assign start = (instr_E[31:26] == 6'd0) && (instr_E[5:2] == 4'b0110);
    assign busy  = (ucnt != 0) && !(drop_early && udiv && ucnt == 1);

    always @(posedge clk) begin
        if (reset) ucnt <= 0;
        else if (req) ucnt <= ucnt;
        else if (ucnt == 0 && start) begin
            ucnt <= instr_E[1] ? 10 : 5;
            udiv <= instr_E[1];
        end else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    typedef struct {
        string tag;
        int s, p, r, e;
        longint c;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            if (x.s >= 0) begin
                tests++;
                if (stall !== 1'(x.s)) begin
                    fails++;
                    $display("FAIL %s stall: got %0b want %0d", x.tag, stall, x.s);
                end
            end
            if (x.p >= 0) begin
                tests++;
                if (pending !== 1'(x.p)) begin
                    fails++;
                    $display("FAIL %s pending: got %0b want %0d", x.tag, pending, x.p);
                end
            end
            if (x.r >= 0) begin
                tests++;
                if (remain !== 4'(x.r)) begin
                    fails++;
                    $display("FAIL %s remain: got %0d want %0d", x.tag, remain, x.r);
                end
            end
            if (x.e >= 0) begin
                tests++;
                if (proto_err !== 1'(x.e)) begin
                    fails++;
                    $display("FAIL %s proto_err: got %0b want %0d", x.tag, proto_err, x.e);
                end
            end
            if (x.c >= 0) begin
                tests++;
                if (stall_cnt !== 32'(x.c)) begin
                    fails++;
                    $display("FAIL %s stall_cnt: got %0d want %0d", x.tag, stall_cnt, x.c);
                end
            end
        end
    end

    // One call per cycle; expectations are for the negedge of that cycle (-1 = don't care)
    task automatic cyc(input logic rst, input logic [31:0] d, input logic [31:0] e,
                       input logic rq, input string tag,
                       input int s, input int p, input int r, input int er, input longint c);
        exp_t x;
        @(posedge clk);
        #1;
        reset   = rst;
        instr_D = d;
        instr_E = e;
        req     = rq;
        x.tag = tag; x.s = s; x.p = p; x.r = r; x.e = er; x.c = c;
        q.push_back(x);
    endtask

    initial begin
        int remv[8];
        int reqv[8];
        remv = '{5, 4, 3, 3, 3, 3, 2, 1};
        reqv = '{0, 0, 1, 1, 1, 0, 0, 0};

        // reset then a lone mult
        cyc(1, NOP, NOP, 0, "rst_pre", -1, -1, -1, -1, -1);
        cyc(1, NOP, NOP, 0, "rst", 0, 0, 0, 0, 0);
        cyc(0, NOP, MULT, 0, "mul_iss", 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, NOP, NOP, 0, "mul_busy", 0, 1, 5 - i, 0, 0);
        cyc(0, NOP, NOP, 0, "mul_done", 0, 0, 0, 0, 0);

        // divu followed by dependent mflo held in D
        cyc(0, MFLO, DIVU, 0, "div_iss", 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            cyc(0, MFLO, NOP, 0, "div_stall", 1, 1, 10 - i, 0, i + 1);
        cyc(0, MFLO, NOP, 0, "div_rel", 0, 0, 0, 0, 11);
        cyc(0, NOP, MFLO, 0, "mflo_in_e", 0, 0, 0, 0, 11);

        // non-md instruction in D while pending never stalls
        cyc(0, ADDU, MULT, 0, "nonmd_iss", 0, 0, 0, 0, 11);
        for (int i = 0; i < 5; i++)
            cyc(0, ADDU, NOP, 0, "nonmd_busy", 0, 1, 5 - i, 0, 11);
        cyc(0, NOP, NOP, 0, "nonmd_done", 0, 0, 0, 0, 11);

        // flush for 3 cycles at remain=3 freezes the countdown, stalls still counted
        cyc(0, NOP, MULT, 0, "req_iss", 0, 0, 0, 0, 11);
        for (int i = 0; i < 8; i++)
            cyc(0, MFHI, NOP, reqv[i][0], "req_hold", 1, 1, remv[i], 0, 11 + i);
        cyc(0, MFHI, NOP, 0, "req_done", 0, 0, 0, 0, 19);

        // unit drops busy a cycle early on div -> sticky protocol error
        drop_early = 1'b1;
        cyc(0, NOP, DIV, 0, "early_iss", 0, 0, 0, 0, 19);
        for (int i = 0; i < 10; i++)
            cyc(0, NOP, NOP, 0, "early_busy", 0, 1, 10 - i, 0, -1);
        cyc(0, NOP, NOP, 0, "early_err", 0, 0, 0, 1, 19);
        cyc(0, NOP, NOP, 0, "early_sticky", 0, 0, 0, 1, 19);
        drop_early = 1'b0;

        // reset mid-divide at remain=4
        cyc(1, NOP, NOP, 0, "rst2_pre", -1, -1, -1, -1, -1);
        cyc(0, NOP, NOP, 0, "rst2", 0, 0, 0, 0, 0);
        cyc(0, MFLO, DIV, 0, "rd_iss", 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, MFLO, NOP, 0, "rd_busy", 1, 1, 10 - i, 0, i + 1);
        cyc(1, MFLO, NOP, 0, "rd_at4", -1, 1, 4, 0, 7);
        cyc(0, NOP, NOP, 0, "rd_after", 0, 0, 0, 0, 0);
        cyc(0, NOP, NOP, 0, "rd_quiet", 0, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: got %0d left want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
